// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: two producers (ALU result, load return) share the single
// register-file write port; loads win by default, a bounded wait protects the ALU.

package rv32_isa;
    localparam int RegWidth     = 32;
    localparam int RegAddrWidth = 5;
endpackage

module regfile_wb_arbiter
    import rv32_isa::*;
#(
    parameter int MaxWait  = 4,
    parameter int CntWidth = 16
) (
    input  logic                    iClk,
    input  logic                    nRst,
    input  logic                    iAlu_Valid,
    output logic                    oAlu_Ready,
    input  logic [RegAddrWidth-1:0] iAlu_Addr,
    input  logic [RegWidth-1:0]     iAlu_Data,
    input  logic                    iMem_Valid,
    output logic                    oMem_Ready,
    input  logic [RegAddrWidth-1:0] iMem_Addr,
    input  logic [RegWidth-1:0]     iMem_Data,
    output logic                    oWriteEn,
    output logic [RegAddrWidth-1:0] oAddr_Rd,
    output logic [RegWidth-1:0]     oRd,
    output logic [1:0]              oGrant,
    output logic [CntWidth-1:0]     oConflicts
);

    localparam int WaitWidth = $clog2(MaxWait + 1);

    logic [WaitWidth-1:0] wait_cnt;
    logic                 alu_forced;
    logic                 both_valid;

    assign alu_forced = (wait_cnt == WaitWidth'(MaxWait));
    assign both_valid = iAlu_Valid && iMem_Valid;

    // ALU only wins a conflict once it has lost MaxWait cycles in a row.
    always_comb begin
        oAlu_Ready = 1'b0;
        oMem_Ready = 1'b0;
        if (nRst) begin
            if (iAlu_Valid && (!iMem_Valid || alu_forced)) begin
                oAlu_Ready = 1'b1;
            end else if (iMem_Valid) begin
                oMem_Ready = 1'b1;
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (!nRst) begin
            oWriteEn   <= 1'b0;
            oAddr_Rd   <= '0;
            oRd        <= '0;
            oGrant     <= 2'b00;
            oConflicts <= '0;
            wait_cnt   <= '0;
        end else begin
            oWriteEn <= 1'b0;
            oGrant   <= 2'b00;

            // x0 writes are accepted and reported in oGrant, but leave the port untouched.
            if (oAlu_Ready) begin
                oGrant <= 2'b01;
                if (iAlu_Addr != '0) begin
                    oWriteEn <= 1'b1;
                    oAddr_Rd <= iAlu_Addr;
                    oRd      <= iAlu_Data;
                end
            end else if (oMem_Ready) begin
                oGrant <= 2'b10;
                if (iMem_Addr != '0) begin
                    oWriteEn <= 1'b1;
                    oAddr_Rd <= iMem_Addr;
                    oRd      <= iMem_Data;
                end
            end

            if (!iAlu_Valid || oAlu_Ready) begin
                wait_cnt <= '0;
            end else if (!alu_forced) begin
                wait_cnt <= wait_cnt + WaitWidth'(1);
            end

            if (both_valid && (oConflicts != {CntWidth{1'b1}})) begin
                oConflicts <= oConflicts + CntWidth'(1);
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter; a second instance with a 4-bit
// conflict counter shares the same inputs to exercise saturation.

module tb_regfile_wb_arbiter;

    logic        iClk;
    logic        nRst;
    logic        alu_valid;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic [4:0]  mem_addr;
    logic [31:0] mem_data;

    logic        alu_ready;
    logic        mem_ready;
    logic        write_en;
    logic [4:0]  addr_rd;
    logic [31:0] rd;
    logic [1:0]  grant;
    logic [15:0] conflicts;

    logic        s_alu_ready;
    logic        s_mem_ready;
    logic        s_write_en;
    logic [4:0]  s_addr_rd;
    logic [31:0] s_rd;
    logic [1:0]  s_grant;
    logic [3:0]  s_conflicts;

    int total = 0;
    int bad   = 0;

    regfile_wb_arbiter #(.MaxWait(4), .CntWidth(16)) dut (
        .iClk(iClk), .nRst(nRst),
        .iAlu_Valid(alu_valid), .oAlu_Ready(alu_ready),
        .iAlu_Addr(alu_addr), .iAlu_Data(alu_data),
        .iMem_Valid(mem_valid), .oMem_Ready(mem_ready),
        .iMem_Addr(mem_addr), .iMem_Data(mem_data),
        .oWriteEn(write_en), .oAddr_Rd(addr_rd), .oRd(rd),
        .oGrant(grant), .oConflicts(conflicts)
    );

    regfile_wb_arbiter #(.MaxWait(4), .CntWidth(4)) dut_sat (
        .iClk(iClk), .nRst(nRst),
        .iAlu_Valid(alu_valid), .oAlu_Ready(s_alu_ready),
        .iAlu_Addr(alu_addr), .iAlu_Data(alu_data),
        .iMem_Valid(mem_valid), .oMem_Ready(s_mem_ready),
        .iMem_Addr(mem_addr), .iMem_Data(mem_data),
        .oWriteEn(s_write_en), .oAddr_Rd(s_addr_rd), .oRd(s_rd),
        .oGrant(s_grant), .oConflicts(s_conflicts)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic mv, input logic [4:0] ma, input logic [31:0] md);
        alu_valid = av;
        alu_addr  = aa;
        alu_data  = ad;
        mem_valid = mv;
        mem_addr  = ma;
        mem_data  = md;
        #1;
    endtask

    task automatic test_reset();
        nRst = 1'b0;
        drive(1'b1, 5'd9, 32'h1111_1111, 1'b1, 5'd10, 32'h2222_2222);
        for (int c = 0; c < 3; c++) begin
            total++;
            if (alu_ready !== 1'b0 || mem_ready !== 1'b0) begin
                bad++;
                $display("[TB] FAIL reset_ready cyc=%0d got alu=%b mem=%b want 0/0", c, alu_ready, mem_ready);
            end
            step();
        end
        total++;
        if (write_en !== 1'b0 || addr_rd !== 5'd0 || rd !== 32'd0 || grant !== 2'b00) begin
            bad++;
            $display("[TB] FAIL reset_outputs got we=%b addr=%0d rd=%h grant=%b want 0/0/0/00",
                     write_en, addr_rd, rd, grant);
        end
        total++;
        if (conflicts !== 16'd0 || s_conflicts !== 4'd0) begin
            bad++;
            $display("[TB] FAIL reset_conflicts got %0d/%0d want 0/0", conflicts, s_conflicts);
        end
    endtask

    task automatic test_single_source();
        nRst = 1'b1;
        drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0);
        total++;
        if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL single_ready got alu=%b mem=%b want 1/0", alu_ready, mem_ready);
        end
        step();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        total++;
        if (write_en !== 1'b1 || addr_rd !== 5'd5 || rd !== 32'hDEAD_BEEF || grant !== 2'b01) begin
            bad++;
            $display("[TB] FAIL single_write got we=%b addr=%0d rd=%h grant=%b want 1/5/deadbeef/01",
                     write_en, addr_rd, rd, grant);
        end
        step();
        total++;
        if (write_en !== 1'b0 || grant !== 2'b00 || addr_rd !== 5'd5 || rd !== 32'hDEAD_BEEF) begin
            bad++;
            $display("[TB] FAIL single_idle got we=%b grant=%b addr=%0d rd=%h want 0/00/5/deadbeef",
                     write_en, grant, addr_rd, rd);
        end
    endtask

    task automatic test_starvation();
        logic        exp_alu;
        logic [4:0]  exp_addr;
        logic [31:0] exp_rd;
        logic [1:0]  exp_grant;
        nRst = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        step();
        nRst = 1'b1;
        // ALU stays valid through cycle 5 with a second request after its grant.
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, 5'd3, 32'hA0A0_0000 + 32'(c), 1'b1, 5'd7, 32'h0000_0100 + 32'(c));
            exp_alu = (c == 4);
            total++;
            if (alu_ready !== exp_alu || mem_ready !== !exp_alu) begin
                bad++;
                $display("[TB] FAIL starve_ready cyc=%0d got alu=%b mem=%b want %b/%b",
                         c, alu_ready, mem_ready, exp_alu, !exp_alu);
            end
            step();
            exp_grant = exp_alu ? 2'b01 : 2'b10;
            exp_addr  = exp_alu ? 5'd3 : 5'd7;
            exp_rd    = exp_alu ? 32'hA0A0_0004 : 32'h0000_0100 + 32'(c);
            total++;
            if (write_en !== 1'b1 || grant !== exp_grant || addr_rd !== exp_addr || rd !== exp_rd) begin
                bad++;
                $display("[TB] FAIL starve_write cyc=%0d got we=%b grant=%b addr=%0d rd=%h want 1/%b/%0d/%h",
                         c, write_en, grant, addr_rd, rd, exp_grant, exp_addr, exp_rd);
            end
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        total++;
        if (conflicts !== 16'd6) begin
            bad++;
            $display("[TB] FAIL starve_conflicts got %0d want 6", conflicts);
        end
    endtask

    task automatic test_x0_drop();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h0000_1234);
        total++;
        if (mem_ready !== 1'b1 || alu_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL x0_ready got mem=%b alu=%b want 1/0", mem_ready, alu_ready);
        end
        step();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        total++;
        if (write_en !== 1'b0 || grant !== 2'b10 || addr_rd !== 5'd7 || rd !== 32'h0000_0105) begin
            bad++;
            $display("[TB] FAIL x0_write got we=%b grant=%b addr=%0d rd=%h want 0/10/7/00000105",
                     write_en, grant, addr_rd, rd);
        end
    endtask

    task automatic test_reset_midstream();
        logic exp_alu;
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 5'd12, 32'hC0DE_0000, 1'b1, 5'd13, 32'hBEEF_0000 + 32'(c));
            step();
        end
        nRst = 1'b0;
        #1;
        total++;
        if (alu_ready !== 1'b0 || mem_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midrst_ready got alu=%b mem=%b want 0/0", alu_ready, mem_ready);
        end
        step();
        total++;
        if (write_en !== 1'b0 || addr_rd !== 5'd0 || rd !== 32'd0 || grant !== 2'b00 || conflicts !== 16'd0) begin
            bad++;
            $display("[TB] FAIL midrst_outputs got we=%b addr=%0d rd=%h grant=%b conf=%0d want all 0",
                     write_en, addr_rd, rd, grant, conflicts);
        end
        nRst = 1'b1;
        // A cleared counter means MEM wins four more times before the ALU.
        for (int c = 0; c < 5; c++) begin
            #1;
            exp_alu = (c == 4);
            total++;
            if (alu_ready !== exp_alu || mem_ready !== !exp_alu) begin
                bad++;
                $display("[TB] FAIL midrst_arb cyc=%0d got alu=%b mem=%b want %b/%b",
                         c, alu_ready, mem_ready, exp_alu, !exp_alu);
            end
            step();
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic test_saturation();
        nRst = 1'b0;
        step();
        nRst = 1'b1;
        drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
        for (int c = 0; c < 20; c++) step();
        total++;
        if (s_conflicts !== 4'hF || conflicts !== 16'd20) begin
            bad++;
            $display("[TB] FAIL sat_count got %h/%0d want f/20", s_conflicts, conflicts);
        end
        for (int c = 0; c < 3; c++) step();
        total++;
        if (s_conflicts !== 4'hF || conflicts !== 16'd23) begin
            bad++;
            $display("[TB] FAIL sat_hold got %h/%0d want f/23", s_conflicts, conflicts);
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        step();
        total++;
        if (s_conflicts !== 4'hF || s_write_en !== 1'b0 || s_grant !== 2'b00) begin
            bad++;
            $display("[TB] FAIL sat_idle got conf=%h we=%b grant=%b want f/0/00",
                     s_conflicts, s_write_en, s_grant);
        end
    endtask

    initial begin
        nRst = 1'b0;
        alu_valid = 1'b0;
        alu_addr  = '0;
        alu_data  = '0;
        mem_valid = 1'b0;
        mem_addr  = '0;
        mem_data  = '0;
        test_reset();
        test_single_source();
        test_starvation();
        test_x0_drop();
        test_reset_midstream();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter that shares the register file's single write port between two producers: the ALU result path and the load (memory) return path. Each producer offers writes over a valid/ready handshake. The arbiter grants at most one write per cycle and registers the winner onto the register-file write port. Load returns win by default, and a bounded-wait counter guarantees ALU forward progress.

## Interface
Parameters:
- MaxWait, 4: ALU cycles lost before the ALU gets forced priority; legal range 1..15.
- CntWidth, 16: width of the conflict performance counter.

Ports (RegWidth = 32 and RegAddrWidth = 5, both from rv32_isa):
- iClk  in  1  clock; all state updates on the rising edge.
- nRst  in  1  reset, synchronous, active-low.
- iAlu_Valid  in  1  ALU write request.
- oAlu_Ready  out  1  ALU write accepted this cycle.
- iAlu_Addr  in  RegAddrWidth  ALU destination register.
- iAlu_Data  in  RegWidth  ALU write data.
- iMem_Valid  in  1  load write request.
- oMem_Ready  out  1  load write accepted this cycle.
- iMem_Addr  in  RegAddrWidth  load destination register.
- iMem_Data  in  RegWidth  load write data.
- oWriteEn  out  1  register-file write enable.
- oAddr_Rd  out  RegAddrWidth  register-file write address.
- oRd  out  RegWidth  register-file write data.
- oGrant  out  2  last accepted source: 2'b01 = ALU, 2'b10 = MEM, 2'b00 = none.
- oConflicts  out  CntWidth  saturating count of cycles with both requests valid.

## Operation
- **Handshake:**
  - A transfer occurs when valid and ready are both high in the same cycle.
  - A producer holds valid, addr and data stable until its transfer occurs.
  - Ready is combinational from both valids, the wait counter and nRst.
  - At most one ready is high in any cycle.
  - A producer's ready is never high while its own valid is low.
- **Arbitration (when nRst is high):**
  - Only MEM valid: MEM is granted.
  - Only ALU valid: ALU is granted.
  - Both valid and wait counter < MaxWait: MEM is granted.
  - Both valid and wait counter == MaxWait: ALU is granted.
- **Wait counter** (internal, $clog2(MaxWait+1) bits):
  - Increments each cycle ALU is valid and not granted, saturating at MaxWait.
  - Clears to 0 on an ALU grant.
  - Clears to 0 in any cycle ALU is not valid.
- **Write register:**
  - On a transfer with addr != 0: next cycle oWriteEn = 1, and oAddr_Rd/oRd carry the granted addr/data.
  - On a transfer with addr == 0: the request is accepted, ready goes high, and oWriteEn = 0 next cycle. The write to x0 is dropped.
  - On no transfer: oWriteEn = 0 next cycle, and oAddr_Rd/oRd hold their previous values.
- **oGrant:** registered alongside oWriteEn; reflects the source of the transfer, including dropped x0 writes. It is 2'b00 when no transfer occurred.
- **oConflicts:** increments by 1 each cycle both valids are high; saturates at all-ones.
- **Reset:**
  - When nRst is low at a rising edge: oWriteEn = 0, oAddr_Rd = 0, oRd = 0, oGrant = 0, oConflicts = 0, wait counter = 0.
  - While nRst is low, oAlu_Ready and oMem_Ready are forced to 0, so no transfer occurs.
  - Reset mid-stream discards any pending write. Producers re-present their requests after reset.

## Timing
- Transfer in cycle N: oWriteEn/oAddr_Rd/oRd are valid in cycle N+1. The register file captures the value at the end of N+1, and it is readable from cycle N+2.
- Throughput: one write per cycle, sustained, with back-to-back grants from either source.
- Worst-case ALU wait under continuous MEM traffic: MaxWait lost cycles. The ALU is granted on the (MaxWait+1)-th cycle of its request.
- After an ALU grant the counter is 0, so a continuously valid MEM wins again the next cycle.
- Both valid in the same cycle as reset release: arbitration starts with the counter at 0.
- Same destination register from both sources in consecutive cycles: the writes apply in grant order, so the later grant's data persists.

## Test plan
- **Reset values:** hold nRst low 3 cycles with both valids high -> both readys 0; oWriteEn 0, oAddr_Rd 0, oRd 0, oGrant 0, oConflicts 0.
- **Single source:** ALU valid, addr 5, data 32'hDEADBEEF for 1 cycle -> oAlu_Ready 1 in cycle N; in N+1 oWriteEn 1, oAddr_Rd 5, oRd 32'hDEADBEEF, oGrant 2'b01; in N+2 oWriteEn 0.
- **Starvation bound:** MaxWait = 4; MEM valid continuously with addr 7; ALU valid from cycle 0 with addr 3 -> MEM granted in cycles 0-3, ALU granted in cycle 4, MEM granted in cycle 5; oConflicts = 6 after cycle 5.
- **x0 drop:** MEM valid, addr 0, data 32'h1234 -> oMem_Ready 1; next cycle oWriteEn 0 and oGrant 2'b10; oAddr_Rd/oRd unchanged.
- **Reset mid-stream:** both valid and counter at 3, then nRst low for 1 cycle -> no transfer that cycle; counter 0 and outputs at reset values; after release MEM is granted first.
- **Saturation:** CntWidth = 4; 20 consecutive conflict cycles -> oConflicts = 4'hF and holds.
